// File: rtl/cache_tag_lookup_ctrl.sv
// rtl/cache_tag_lookup_ctrl.sv - lookup/allocate controller in front of a synchronous-read tag RAM
// One lookup at a time: read the indexed entry, compare, optionally allocate; flush sweeps all entries to 0.
module cache_tag_lookup_ctrl #(
   parameter int AWIDTH = 3,
   parameter int DWIDTH = 7,
   localparam int TAGW  = DWIDTH - 1,
   localparam int DEPTH = 1 << AWIDTH
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [TAGW+AWIDTH-1:0] req_addr,
   input  logic                   req_alloc,
   input  logic                   flush,
   output logic                   busy,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_hit,
   output logic                   rsp_vic_valid,
   output logic [TAGW-1:0]        rsp_vic_tag,
   output logic [AWIDTH-1:0]      tr_addr,
   output logic [DWIDTH-1:0]      tr_din,
   output logic                   tr_we,
   input  logic [DWIDTH-1:0]      tr_dout
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_COMPARE, S_UPDATE, S_RESP, S_FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [TAGW-1:0]   tag_q, tag_d;
   logic [AWIDTH-1:0] idx_q, idx_d;
   logic              alloc_q, alloc_d;
   logic              hit_q, hit_d;
   logic              vic_valid_q, vic_valid_d;
   logic [TAGW-1:0]   vic_tag_q, vic_tag_d;
   logic [AWIDTH-1:0] fl_cnt_q, fl_cnt_d;
   logic              cmp_hit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         tag_q       <= '0;
         idx_q       <= '0;
         alloc_q     <= 1'b0;
         hit_q       <= 1'b0;
         vic_valid_q <= 1'b0;
         vic_tag_q   <= '0;
         fl_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         idx_q       <= idx_d;
         alloc_q     <= alloc_d;
         hit_q       <= hit_d;
         vic_valid_q <= vic_valid_d;
         vic_tag_q   <= vic_tag_d;
         fl_cnt_q    <= fl_cnt_d;
      end
   end

   // RAM word is valid in COMPARE: the address was latched at the LOOKUP closing edge.
   assign cmp_hit = tr_dout[DWIDTH-1] & (tr_dout[TAGW-1:0] == tag_q);

   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      idx_d       = idx_q;
      alloc_d     = alloc_q;
      hit_d       = hit_q;
      vic_valid_d = vic_valid_q;
      vic_tag_d   = vic_tag_q;
      fl_cnt_d    = fl_cnt_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      busy        = 1'b0;
      tr_we       = 1'b0;
      tr_din      = '0;
      tr_addr     = idx_q;
      case (state_q)
         S_IDLE: begin
            req_ready = ~flush;
            if (flush) begin
               fl_cnt_d = '0;
               state_d  = S_FLUSH;
            end else if (req_valid) begin
               tag_d   = req_addr[TAGW+AWIDTH-1:AWIDTH];
               idx_d   = req_addr[AWIDTH-1:0];
               alloc_d = req_alloc;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: state_d = S_COMPARE;
         S_COMPARE: begin
            hit_d       = cmp_hit;
            vic_valid_d = tr_dout[DWIDTH-1];
            vic_tag_d   = tr_dout[TAGW-1:0];
            state_d     = (~cmp_hit & alloc_q) ? S_UPDATE : S_RESP;
         end
         S_UPDATE: begin
            tr_we   = 1'b1;
            tr_din  = {1'b1, tag_q};
            state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         S_FLUSH: begin
            busy    = 1'b1;
            tr_we   = 1'b1;
            tr_addr = fl_cnt_q;
            // Stop on the last entry rather than wrapping, so exactly DEPTH writes issue.
            if (fl_cnt_q == AWIDTH'(DEPTH - 1)) begin
               fl_cnt_d = '0;
               state_d  = S_IDLE;
            end else begin
               fl_cnt_d = fl_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rsp_hit       = hit_q;
   assign rsp_vic_valid = vic_valid_q;
   assign rsp_vic_tag   = vic_tag_q;

endmodule

// File: tb/tb_cache_tag_lookup_ctrl.sv
// tb/tb_cache_tag_lookup_ctrl.sv - scoreboard bench for cache_tag_lookup_ctrl with tag RAM model
module tb_cache_tag_lookup_ctrl;
   localparam int AW = 3;
   localparam int DW = 7;
   localparam int TW = 6;
   localparam int DEPTH = 8;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [TW+AW-1:0] req_addr = '0;
   logic          req_alloc = 1'b0;
   logic          flush = 1'b0;
   logic          busy;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic          rsp_hit;
   logic          rsp_vic_valid;
   logic [TW-1:0] rsp_vic_tag;
   logic [AW-1:0] tr_addr;
   logic [DW-1:0] tr_din;
   logic          tr_we;
   logic [DW-1:0] tr_dout;

   always #5 clock = ~clock;

   cache_tag_lookup_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_alloc(req_alloc),
      .flush(flush), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
      .rsp_vic_valid(rsp_vic_valid), .rsp_vic_tag(rsp_vic_tag),
      .tr_addr(tr_addr), .tr_din(tr_din), .tr_we(tr_we), .tr_dout(tr_dout)
   );

   // Tag RAM: registered address, array read, no reset.
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] ram_addr_q = '0;
   always @(posedge clock) begin
      if (tr_we) mem[tr_addr] <= tr_din;
      ram_addr_q <= tr_addr;
   end
   assign tr_dout = mem[ram_addr_q];

   typedef struct {
      bit            hit;
      bit            vv;
      logic [TW-1:0] vt;
      int            acc;
      int            lat;
   } rsp_t;
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   rsp_t rq[$];
   wr_t  wq[$];
   logic [DW-1:0] model [DEPTH];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit in_rsp = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every RAM write and every response cycle is checked against the queues.
   always @(negedge clock) begin
      if (reset_n) begin
         if (tr_we) begin
            if (wq.size() == 0) chk("spurious_write", {29'd0, tr_addr}, 32'hFFFF_FFFF);
            else begin
               chk("wr_addr", 32'(tr_addr), 32'(wq[0].a));
               chk("wr_din", 32'(tr_din), 32'(wq[0].d));
               void'(wq.pop_front());
            end
         end
         if (rsp_valid) begin
            chk("rsp_with_req_ready", 32'(req_ready), 32'd0);
            if (rq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
               if (!in_rsp) chk("rsp_latency", 32'(cyc - rq[0].acc), 32'(rq[0].lat));
               chk("rsp_hit", 32'(rsp_hit), 32'(rq[0].hit));
               chk("rsp_vic_valid", 32'(rsp_vic_valid), 32'(rq[0].vv));
               chk("rsp_vic_tag", 32'(rsp_vic_tag), 32'(rq[0].vt));
               if (rsp_ready) void'(rq.pop_front());
            end
         end
      end
      in_rsp <= reset_n & rsp_valid & ~rsp_ready;
   end

   task automatic do_req(input logic [TW-1:0] tag, input logic [AW-1:0] idx, input bit alloc,
                         input int hold, input bit noise);
      logic [DW-1:0] ent;
      rsp_t r;
      wr_t w;
      int n;
      bit miss_alloc;
      req_valid = 1'b1;
      req_addr  = {tag, idx};
      req_alloc = alloc;
      rsp_ready = (hold == 0);
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'd1, 32'd0);
         req_valid = 1'b0;
         return;
      end
      ent = model[idx];
      r.hit = ent[DW-1] && (ent[TW-1:0] == tag);
      r.vv  = ent[DW-1];
      r.vt  = ent[TW-1:0];
      r.acc = cyc;
      miss_alloc = !r.hit && alloc;
      r.lat = miss_alloc ? 4 : 3;
      rq.push_back(r);
      if (miss_alloc) begin
         w.a = idx;
         w.d = {1'b1, tag};
         wq.push_back(w);
         model[idx] = {1'b1, tag};
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(posedge clock); #1;
         n++;
      end
      if (!rsp_valid) begin
         chk("rsp_timeout", 32'd1, 32'd0);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         if (noise) begin
            req_valid = 1'b1;
            flush     = 1'b1;
            req_addr  = 9'($urandom);
         end
         @(posedge clock); #1;
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         chk("hold_busy", 32'(busy), 32'd0);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      req_valid = 1'b0;
      flush     = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      chk("post_rsp_idle", 32'({req_ready, busy, rsp_valid}), 32'b100);
   endtask

   task automatic do_flush();
      wr_t w;
      int n;
      flush = 1'b1;
      #1;
      chk("flush_blocks_req_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         w.a = AW'(i);
         w.d = '0;
         wq.push_back(w);
         model[i] = '0;
      end
      @(posedge clock); #1;
      flush = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk("flush_busy_cycles", 32'(n), 32'd8);
      chk("flush_done_req_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tr_we"}, 32'(tr_we), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
   endtask

   task automatic rand_reqs(input int cnt);
      for (int i = 0; i < cnt; i++)
         do_req(6'($urandom_range(0, 3) * 17), AW'($urandom_range(0, DEPTH - 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
   endtask

   initial begin
      int n;
      #1;
      check_reset_outputs("reset");
      chk("reset_tr_addr", 32'(tr_addr), 32'd0);
      chk("reset_tr_din", 32'(tr_din), 32'd0);
      chk("reset_rsp_fields", 32'({rsp_hit, rsp_vic_valid, rsp_vic_tag}), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock); #1;

      do_flush();
      do_req(6'h15, 3'd2, 1'b1, 0, 1'b0);
      do_req(6'h15, 3'd2, 1'b0, 0, 1'b0);
      do_req(6'h2A, 3'd2, 1'b1, 0, 1'b0);
      do_req(6'h2A, 3'd2, 1'b0, 5, 1'b1);
      rand_reqs(40);

      // Reset in COMPARE of a would-be allocating miss: no write, no response.
      req_valid = 1'b1;
      req_addr  = {6'h3F, 3'd5};
      req_alloc = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("rst_compare");
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      check_reset_outputs("after_rst_compare");
      rand_reqs(10);

      // Reset while the flush sweep is at entry 4.
      flush = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         wr_t w;
         w.a = AW'(i);
         w.d = '0;
         wq.push_back(w);
      end
      @(posedge clock); #1;
      flush = 1'b0;
      n = 0;
      while (!(busy && tr_addr == 3'd4) && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk("abort_reached_4", 32'({busy, tr_addr}), 32'({1'b1, 3'd4}));
      reset_n = 1'b0;
      #1;
      check_reset_outputs("rst_flush");
      chk("abort_pending_writes", 32'(wq.size()), 32'd4);
      wq.delete();
      for (int i = 0; i < 4; i++) model[i] = '0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      check_reset_outputs("after_rst_flush");
      for (int i = 0; i < DEPTH; i++) do_req(6'h3F, AW'(i), 1'b0, 0, 1'b0);

      do_flush();
      rand_reqs(10);
      repeat (3) @(posedge clock);
      #1;
      chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
      chk("wr_queue_empty", 32'(wq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
